lsu_align: RTL

- Load/store alignment unit between the core's execute stage and the data RAM.
- Accepts one RV32I load/store request at a time and drives the RAM port: we, 2-bit mem_ctrl, byte address, write data.
- Sign- or zero-extends the RAM's registered read data back to the core.
- Misaligned accesses are either split into byte sub-accesses or trapped, selected by parameter.

---
 rtl/lsu_align_pkg.sv | 34 +++
 rtl/lsu_load_ext.sv | 26 ++
 rtl/lsu_align.sv | 117 +++++++++++
 3 files changed

// File: rtl/lsu_align_pkg.sv
// Shared encodings for the load/store alignment unit: RV32I funct3 codes,
// RAM store-size codes, FSM states and the latched request record.
package lsu_align_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] STORE_B  = 2'b00;
  localparam logic [1:0] STORE_HW = 2'b01;
  localparam logic [1:0] STORE_W  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic        split;
    logic        err;
  } lsu_req_t;

  // Stores only have SB/SH/SW; loads add LBU/LHU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (we && (f3 == F3_LBU || f3 == F3_LHU));
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extraction: picks the byte/half lane and sign/zero-extends.
module lsu_load_ext
  import lsu_align_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = data[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LBU:  result = {24'b0, b};
      F3_LHU:  result = {16'b0, h};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: one request at a time, aligned accesses go out
// as one RAM op, misaligned ones are split into bytes or trapped.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [1:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state, state_nxt;
  lsu_req_t          rq;
  logic [ADDR_W-1:0] r_addr, piece_addr;
  logic [1:0]        k, k_last;
  logic [31:0]       buf_q, ext;
  logic              acc, last, in_mis, in_err;

  always_comb begin
    acc    = req_valid && req_ready;
    in_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    in_err = f3_illegal(req_we, req_funct3) || (in_mis && !SPLIT_MISALIGNED);
    k_last = rq.split ? (rq.funct3[1] ? 2'd3 : 2'd1) : 2'd0;
    last   = (k == k_last);
    piece_addr = r_addr + ADDR_W'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc) state_nxt = in_err ? S_RESP : S_ISSUE;
      S_ISSUE: if (!rq.we) state_nxt = S_WAIT;
               else if (last) state_nxt = S_RESP;
      S_WAIT:  state_nxt = last ? S_RESP : S_ISSUE;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Piece counter k advances per store write or per load read-return.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq     <= '0;
      r_addr <= '0;
      k      <= '0;
      buf_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (acc) begin
          rq.we     <= req_we;
          rq.funct3 <= req_funct3;
          rq.wdata  <= req_wdata;
          rq.split  <= in_mis;
          rq.err    <= in_err;
          r_addr    <= req_addr;
          k         <= '0;
        end
        S_ISSUE: if (rq.we) k <= k + 2'd1;
        S_WAIT: begin
          if (rq.split) buf_q[{k, 3'b000} +: 8] <= mem_rdata[{piece_addr[1:0], 3'b000} +: 8];
          else          buf_q <= mem_rdata;
          k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Split loads land right-justified in buf_q, so lane select is only for aligned ones.
  lsu_load_ext u_ext (
    .funct3  (rq.funct3),
    .data    (buf_q),
    .addr_lo (rq.split ? 2'b00 : r_addr[1:0]),
    .result  (ext)
  );

  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    mem_we     = (state == S_ISSUE) && rq.we && !rst;
    mem_addr   = rq.we ? piece_addr : {piece_addr[ADDR_W-1:2], 2'b00};
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && rq.err;
    resp_rdata = (state == S_RESP && !rq.err && !rq.we) ? ext : 32'h0;
    if (rq.split) begin
      mem_ctrl  = STORE_B;
      mem_wdata = {24'b0, rq.wdata[{k, 3'b000} +: 8]};
    end else begin
      case (rq.funct3[1:0])
        2'b00:   begin mem_ctrl = STORE_B;  mem_wdata = {24'b0, rq.wdata[7:0]};  end
        2'b01:   begin mem_ctrl = STORE_HW; mem_wdata = {16'b0, rq.wdata[15:0]}; end
        default: begin mem_ctrl = STORE_W;  mem_wdata = rq.wdata;                end
      endcase
    end
  end

endmodule
